// File: rtl/cpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cpu_pkg : shared word width, opcodes and fetch-stage state types |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package cpu_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [0:0] {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/next_pc_calc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | next_pc_calc : sequential PC+4 or branch/jump redirect target    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [WORD_W-1:0] i_pc,
  input  logic              i_branch_taken,
  input  logic [WORD_W-1:0] i_branch_pc4,
  input  logic [15:0]       i_branch_offset,
  input  logic              i_jump,
  input  logic [25:0]       i_jump_field,
  output logic [WORD_W-1:0] o_next_pc,
  output logic              o_redirect
);

  logic [WORD_W-1:0] w_br_disp;
  logic [WORD_W-1:0] w_br_target;
  logic [WORD_W-1:0] w_j_target;

  assign w_br_disp   = {{14{i_branch_offset[15]}}, i_branch_offset, 2'b00};
  assign w_br_target = i_branch_pc4 + w_br_disp;
  assign w_j_target  = {i_branch_pc4[31:28], i_jump_field, 2'b00};
  assign o_redirect  = i_branch_taken | i_jump;

  // Branch wins when both are flagged in the same cycle.
  always_comb begin
    o_next_pc = i_pc + 32'd4;
    if (i_branch_taken) begin
      o_next_pc = w_br_target;
    end else if (i_jump) begin
      o_next_pc = w_j_target;
    end
  end

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | if_fetch_stage : PC owner, imem req/ack handshake, IF/ID feeder  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc4,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_field,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] PC4,
  output logic [31:0] instrucao,
  output logic        fetch_valid
);

  import cpu_pkg::*;

  fetch_state_t      r_state;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_req_addr;
  logic              r_drop;
  logic              r_outst;

  logic              w_req;
  logic              w_ack;
  logic              w_capture;
  logic              w_redirect;
  logic [WORD_W-1:0] w_next_pc;

  next_pc_calc u_next_pc (
    .i_pc           (r_pc),
    .i_branch_taken (branch_taken),
    .i_branch_pc4   (branch_pc4),
    .i_branch_offset(branch_offset),
    .i_jump         (jump),
    .i_jump_field   (jump_field),
    .o_next_pc      (w_next_pc),
    .o_redirect     (w_redirect)
  );

  // An outstanding request must stay up until acked, even under stall.
  assign w_req     = (r_state == S_REQ) && !reset && (r_outst || !stall);
  assign imem_req  = w_req;
  assign imem_addr = r_drop ? r_req_addr : r_pc;
  assign w_ack     = w_req && imem_ack;
  assign w_capture = w_ack && !r_drop && !w_redirect;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC;
      r_req_addr  <= RESET_PC;
      r_drop      <= 1'b0;
      r_outst     <= 1'b0;
      PC4         <= '0;
      instrucao   <= NOP_WORD;
      fetch_valid <= 1'b0;
    end else begin
      fetch_valid <= w_capture;
      if (w_capture) begin
        instrucao <= imem_rdata;
        PC4       <= w_next_pc;
      end
      if (w_redirect || w_capture) begin
        r_pc <= w_next_pc;
      end
      if (w_req) begin
        r_req_addr <= imem_addr;
      end
      r_outst <= w_req && !imem_ack;

      // A redirect under an unacked request leaves its response to be discarded.
      if (w_ack) begin
        r_drop <= 1'b0;
      end else if (w_redirect && w_req) begin
        r_drop <= 1'b1;
      end

      case (r_state)
        S_REQ:   if (stall && !(w_req && !imem_ack)) r_state <= S_HOLD;
        S_HOLD:  if (!stall) r_state <= S_REQ;
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_if_fetch_stage : directed vector table plus random run        |
// | against a transaction-level fetch model. Rev 1.0                 |
// +------------------------------------------------------------------+
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam int          N_RAND = 3000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_pc4 = '0;
  logic [15:0] branch_offset = '0;
  logic        jump = 1'b0;
  logic [25:0] jump_field = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] PC4;
  logic [31:0] instrucao;
  logic        fetch_valid;

  always #5 clock = ~clock;

  if_fetch_stage #(.RESET_PC(RST_PC), .NOP_WORD(NOP)) dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_pc4   (branch_pc4),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_field   (jump_field),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ack     (imem_ack),
    .PC4          (PC4),
    .instrucao    (instrucao),
    .fetch_valid  (fetch_valid)
  );

  typedef struct {
    bit          rst;
    bit          stl;
    bit          bt;
    logic [31:0] bpc4;
    logic [15:0] off;
    bit          jmp;
    logic [25:0] jf;
    bit          ack;
    logic [31:0] rdata;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_fv;
    logic [31:0] e_pc4;
    logic [31:0] e_ins;
  } vec_t;

  vec_t vq[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Pending control fields for the next row; cleared after each row.
  bit          c_rst, c_stl, c_bt, c_jmp;
  logic [31:0] c_bpc4;
  logic [15:0] c_off;
  logic [25:0] c_jf;

  // Model: a request is either fresh (from pc) or pinned to an earlier address.
  bit          m_hold, m_busy, m_disc, m_fv, m_req;
  logic [31:0] m_pc, m_baddr, m_pc4, m_ins, m_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic row(input bit ack, input logic [31:0] rdata, input bit e_req,
                     input logic [31:0] e_addr, input bit e_fv,
                     input logic [31:0] e_pc4, input logic [31:0] e_ins);
    vec_t v;
    v.rst = c_rst; v.stl = c_stl; v.bt = c_bt; v.bpc4 = c_bpc4; v.off = c_off;
    v.jmp = c_jmp; v.jf = c_jf; v.ack = ack; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_fv = e_fv; v.e_pc4 = e_pc4; v.e_ins = e_ins;
    vq.push_back(v);
    c_rst = 0; c_stl = 0; c_bt = 0; c_jmp = 0; c_bpc4 = '0; c_off = '0; c_jf = '0;
  endtask

  function automatic logic [31:0] target();
    logic [31:0] sext;
    sext = {{16{branch_offset[15]}}, branch_offset};
    if (branch_taken) return branch_pc4 + sext * 32'd4;
    return {branch_pc4[31:28], jump_field, 2'b00};
  endfunction

  task automatic model_expect();
    m_req  = !reset && !m_hold && (m_busy || !stall);
    m_addr = m_busy ? m_baddr : m_pc;
  endtask

  task automatic model_advance();
    bit redir, got;
    if (reset) begin
      m_pc = RST_PC; m_hold = 0; m_busy = 0; m_disc = 0;
      m_fv = 0; m_pc4 = '0; m_ins = NOP;
      return;
    end
    redir = branch_taken || jump;
    got   = m_req && imem_ack;
    m_fv  = got && !m_disc && !redir;
    if (m_fv) begin
      m_ins = imem_rdata;
      m_pc4 = m_pc + 32'd4;
    end
    if (redir) m_pc = target();
    else if (m_fv) m_pc = m_pc + 32'd4;
    if (m_req && !imem_ack) begin
      m_baddr = m_addr;
      m_busy  = 1;
      if (redir) m_disc = 1;
    end else if (got) begin
      m_busy = 0;
      m_disc = 0;
    end
    m_hold = stall && !m_busy;
  endtask

  // Entered just after a rising edge; returns just after the next one.
  task automatic run_cycle(input bit rnd, input vec_t v);
    reset = v.rst; stall = v.stl; branch_taken = v.bt; branch_pc4 = v.bpc4;
    branch_offset = v.off; jump = v.jmp; jump_field = v.jf;
    imem_rdata = v.rdata; imem_ack = 1'b0;
    #2;
    model_expect();
    if (rnd) begin
      check("imem_req", imem_req, m_req);
      if (m_req) check("imem_addr", imem_addr, m_addr);
      imem_ack = imem_req && ($urandom_range(0, 2) != 0);
    end else begin
      check("imem_req", imem_req, v.e_req);
      if (v.e_req) check("imem_addr", imem_addr, v.e_addr);
      imem_ack = v.ack;
    end
    #1;
    model_advance();
    @(posedge clock);
    #1;
    if (rnd) begin
      check("fetch_valid", fetch_valid, m_fv);
      check("PC4", PC4, m_pc4);
      check("instrucao", instrucao, m_ins);
    end else begin
      check("fetch_valid", fetch_valid, v.e_fv);
      check("PC4", PC4, v.e_pc4);
      check("instrucao", instrucao, v.e_ins);
    end
  endtask

  initial begin
    vec_t v;
    c_rst = 0; c_stl = 0; c_bt = 0; c_jmp = 0; c_bpc4 = '0; c_off = '0; c_jf = '0;
    m_pc = RST_PC; m_hold = 0; m_busy = 0; m_disc = 0; m_fv = 0; m_req = 0;
    m_baddr = '0; m_pc4 = '0; m_ins = NOP; m_addr = '0;

    // Zero-wait memory from reset
    c_rst = 1; row(0, 32'h0, 0, 32'h0, 0, 32'h0, NOP);
    row(1, 32'hA000_0000, 1, 32'h0, 1, 32'h4,  32'hA000_0000);
    row(1, 32'hA000_0001, 1, 32'h4, 1, 32'h8,  32'hA000_0001);
    row(1, 32'hA000_0002, 1, 32'h8, 1, 32'hC,  32'hA000_0002);
    row(1, 32'hA000_0003, 1, 32'hC, 1, 32'h10, 32'hA000_0003);
    // Three-cycle ack delay
    c_rst = 1; row(0, 32'h0, 0, 32'h0, 0, 32'h0, NOP);
    for (int i = 0; i < 3; i++) row(0, 32'h0, 1, 32'h0, 0, 32'h0, NOP);
    row(1, 32'hB000_0000, 1, 32'h0, 1, 32'h4, 32'hB000_0000);
    row(0, 32'h0,         1, 32'h4, 0, 32'h4, 32'hB000_0000);
    // Stall after first word, then resume at 0x4
    c_rst = 1; row(0, 32'h0, 0, 32'h0, 0, 32'h0, NOP);
    row(1, 32'hC000_0000, 1, 32'h0, 1, 32'h4, 32'hC000_0000);
    for (int i = 0; i < 4; i++) begin
      c_stl = 1; row(0, 32'h0, 0, 32'h0, 0, 32'h4, 32'hC000_0000);
    end
    row(0, 32'h0,         0, 32'h0, 0, 32'h4, 32'hC000_0000);
    row(1, 32'hC000_0001, 1, 32'h4, 1, 32'h8, 32'hC000_0001);
    // Branch while request to 0x14 is outstanding
    c_rst = 1; row(0, 32'h0, 0, 32'h0, 0, 32'h0, NOP);
    for (int i = 0; i < 5; i++)
      row(1, 32'hD000_0000 + i, 1, 32'(4 * i), 1, 32'(4 * i + 4), 32'hD000_0000 + i);
    row(0, 32'h0, 1, 32'h14, 0, 32'h14, 32'hD000_0004);
    c_bt = 1; c_bpc4 = 32'h10; c_off = 16'hFFFE;
    row(0, 32'h0,         1, 32'h14, 0, 32'h14, 32'hD000_0004);
    row(1, 32'hDEAD_BEEF, 1, 32'h14, 0, 32'h14, 32'hD000_0004);
    row(1, 32'hD000_0005, 1, 32'h8,  1, 32'hC,  32'hD000_0005);
    // Jump with same-cycle ack, then branch+jump together
    c_jmp = 1; c_bpc4 = 32'h1000_0020; c_jf = 26'h000_0040;
    row(1, 32'hDEAD_BEEF, 1, 32'hC,         0, 32'hC,         32'hD000_0005);
    row(1, 32'hE000_0000, 1, 32'h1000_0100, 1, 32'h1000_0104, 32'hE000_0000);
    c_bt = 1; c_jmp = 1; c_bpc4 = 32'h100; c_off = 16'h0004; c_jf = 26'h3FF_FFFF;
    row(1, 32'hDEAD_BEEF, 1, 32'h1000_0104, 0, 32'h1000_0104, 32'hE000_0000);
    row(1, 32'hE000_0001, 1, 32'h110,       1, 32'h114,       32'hE000_0001);
    // Reset during a wait; the late ack lands inside reset
    row(0, 32'h0, 1, 32'h114, 0, 32'h114, 32'hE000_0001);
    c_rst = 1; row(0, 32'h0, 0, 32'h0, 0, 32'h0, NOP);
    c_rst = 1; row(1, 32'hDEAD_BEEF, 0, 32'h0, 0, 32'h0, NOP);
    row(0, 32'h0,         1, 32'h0, 0, 32'h0, NOP);
    row(1, 32'hF000_0000, 1, 32'h0, 1, 32'h4, 32'hF000_0000);
    // PC wrap, redirect in hold, stall arriving with ack
    c_bt = 1; c_bpc4 = 32'h0; c_off = 16'hFFFF;
    row(1, 32'hDEAD_BEEF, 1, 32'h4,         0, 32'h4, 32'hF000_0000);
    row(1, 32'h6000_0000, 1, 32'hFFFF_FFFC, 1, 32'h0, 32'h6000_0000);
    row(1, 32'h6000_0001, 1, 32'h0,         1, 32'h4, 32'h6000_0001);
    c_stl = 1; c_bt = 1; c_bpc4 = 32'h200; c_off = 16'h0;
    row(0, 32'h0,         0, 32'h0,   0, 32'h4,   32'h6000_0001);
    row(0, 32'h0,         0, 32'h0,   0, 32'h4,   32'h6000_0001);
    row(1, 32'h6000_0002, 1, 32'h200, 1, 32'h204, 32'h6000_0002);
    row(0, 32'h0,         1, 32'h204, 0, 32'h204, 32'h6000_0002);
    c_stl = 1;
    row(1, 32'h6000_0003, 1, 32'h204, 1, 32'h208, 32'h6000_0003);
    row(0, 32'h0,         0, 32'h0,   0, 32'h208, 32'h6000_0003);
    row(1, 32'h6000_0004, 1, 32'h208, 1, 32'h20C, 32'h6000_0004);

    @(posedge clock);
    #1;
    foreach (vq[i]) run_cycle(0, vq[i]);

    // Random traffic against the model
    for (int i = 0; i < N_RAND; i++) begin
      v.rst   = ($urandom_range(0, 63) == 0);
      v.stl   = ($urandom_range(0, 9) < 3);
      v.bt    = ($urandom_range(0, 9) == 0);
      v.jmp   = ($urandom_range(0, 9) == 0);
      v.bpc4  = $urandom;
      v.off   = 16'($urandom);
      v.jf    = 26'($urandom);
      v.ack   = 0;
      v.rdata = $urandom;
      v.e_req = 0; v.e_addr = '0; v.e_fv = 0; v.e_pc4 = '0; v.e_ins = '0;
      run_cycle(1, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
